// File: rtl/ovrd_piecevise_unclamp.sv
// Inverse of the overdrive piecewise soft clamp: recovers x from y = (3x - x^3)/4
// by a bits_per_level-step bisection on the magnitude, then restores the sign.
module ovrd_piecevise_unclamp #(
  parameter int bits_per_level = 12,
  parameter int fxp_size       = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic signed [fxp_size-1:0] i_sample,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic signed [fxp_size-1:0] o_sample,
  output logic                       o_valid,
  input  logic                       i_ready
);

  localparam int LW = bits_per_level + 1;
  localparam int FW = 3 * (bits_per_level + 2);
  localparam int MW = fxp_size - 1;
  localparam int CW = (FW > MW) ? FW : MW;
  localparam int IW = $clog2(bits_per_level + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [LW-1:0]       ONE_LEVEL  = {1'b1, {bits_per_level{1'b0}}};
  localparam logic [MW-1:0]       HALF_LEVEL = {{(MW-bits_per_level){1'b0}}, 1'b1, {(bits_per_level-1){1'b0}}};
  localparam logic [fxp_size-1:0] MOST_NEG   = {1'b1, {MW{1'b0}}};
  localparam logic [IW-1:0]       LAST_ITER  = IW'(bits_per_level - 1);
  localparam logic [IW-1:0]       ITER_STEP  = {{(IW-1){1'b0}}, 1'b1};

  logic [1:0]    state_r;
  logic [LW-1:0] lo_r;
  logic [LW-1:0] hi_r;
  logic          sign_r;
  logic [MW-1:0] mag_r;
  logic [IW-1:0] iter_r;

  logic [MW-1:0] mag_in_s;
  logic          sat_in_s;
  logic [LW:0]   sum_s;
  logic [LW-1:0] mid_s;
  logic [FW-1:0] mid_x_s;
  logic [FW-1:0] lin_s;
  logic [FW-1:0] cube_s;
  logic [FW-1:0] fm_s;
  logic          go_lo_s;
  logic [LW-1:0] lo_nx_s;
  logic [LW-1:0] hi_nx_s;
  logic [LW-1:0] result_s;

  function automatic logic [fxp_size-1:0] apply_sign(input logic neg, input logic [LW-1:0] val);
    logic [fxp_size-1:0] ext;
    ext = fxp_size'(val);
    if (neg) begin
      return -ext;
    end else begin
      return ext;
    end
  endfunction

  // Magnitude of the incoming sample; the most negative code clamps to the largest magnitude
  always_comb begin
    mag_in_s = '0;
    if (!i_sample[fxp_size-1]) begin
      mag_in_s = i_sample[MW-1:0];
    end else if (i_sample == MOST_NEG) begin
      mag_in_s = {MW{1'b1}};
    end else begin
      mag_in_s = MW'(-i_sample);
    end
    sat_in_s = (mag_in_s >= HALF_LEVEL);
  end

  // One bisection step: evaluate f(mid) at full precision and narrow the bracket
  always_comb begin
    sum_s   = {1'b0, lo_r} + {1'b0, hi_r};
    mid_s   = LW'(sum_s >> 1'b1);
    mid_x_s = FW'(mid_s);
    lin_s   = {mid_x_s[FW-2:0], 1'b0} + mid_x_s;
    cube_s  = mid_x_s * mid_x_s * mid_x_s;
    fm_s    = (lin_s - (cube_s >> (2 * bits_per_level))) >> 2'd2;
    go_lo_s = (CW'(fm_s) <= CW'(mag_r));
    if (go_lo_s) begin
      lo_nx_s = mid_s;
      hi_nx_s = hi_r;
    end else begin
      lo_nx_s = lo_r;
      hi_nx_s = mid_s;
    end
    // f(1) truncates to 0, so a zero input is pinned to zero rather than the floor inverse
    if (mag_r == '0) begin
      result_s = '0;
    end else begin
      result_s = lo_nx_s;
    end
  end

  // Control FSM, search bracket and registered output handshake
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r  <= IDLE;
      lo_r     <= '0;
      hi_r     <= '0;
      sign_r   <= 1'b0;
      mag_r    <= '0;
      iter_r   <= '0;
      o_ready  <= 1'b1;
      o_valid  <= 1'b0;
      o_sample <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_valid && o_ready) begin
            sign_r  <= i_sample[fxp_size-1];
            mag_r   <= mag_in_s;
            o_ready <= 1'b0;
            if (sat_in_s) begin
              o_valid  <= 1'b1;
              o_sample <= apply_sign(i_sample[fxp_size-1], ONE_LEVEL);
              state_r  <= DONE;
            end else begin
              lo_r    <= '0;
              hi_r    <= ONE_LEVEL;
              iter_r  <= '0;
              state_r <= CALC;
            end
          end
        end
        CALC: begin
          lo_r <= lo_nx_s;
          hi_r <= hi_nx_s;
          if (iter_r == LAST_ITER) begin
            o_valid  <= 1'b1;
            o_sample <= apply_sign(sign_r, result_s);
            state_r  <= DONE;
          end else begin
            iter_r <= iter_r + ITER_STEP;
          end
        end
        DONE: begin
          if (o_valid && i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state_r <= IDLE;
          end
        end
        default: begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ovrd_piecevise_unclamp.sv
// Randomized and directed bench for ovrd_piecevise_unclamp against a floor-inverse
// lookup table built from the forward clamp formula.
module tb_ovrd_piecevise_unclamp;

  localparam int BPL  = 12;
  localparam int ONE  = 4096;
  localparam int HALF = 2048;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [31:0] i_sample;
  logic               i_valid;
  logic               o_ready;
  logic signed [31:0] o_sample;
  logic               o_valid;
  logic               i_ready;

  typedef struct {
    logic [31:0] exp;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          last_acc = 0;
  int          last_hs = 0;
  int          prev_acc = -1;
  bit          chk_period = 1'b0;
  bit          mono_on = 1'b0;
  bit          mono_have = 1'b0;
  logic [31:0] mono_prev = 32'd0;
  int          rdy_mode = 0;
  int          tab[HALF];

  ovrd_piecevise_unclamp #(.bits_per_level(BPL), .fxp_size(32)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_sample (i_sample),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_sample (o_sample),
    .o_valid  (o_valid),
    .i_ready  (i_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d @cyc %0d", tag, $signed(got), $signed(exp), cyc);
    end
  endtask

  // forward clamp on [0, one_level] in plain integer arithmetic
  function automatic longint fwd(input longint x);
    return (3 * x - ((x * x * x) >>> (2 * BPL))) >>> 2;
  endfunction

  function automatic longint mag_of(input logic [31:0] y);
    if (y[31]) return -longint'($signed(y));
    else return longint'(y);
  endfunction

  function automatic logic [31:0] model_val(input logic [31:0] y);
    longint m;
    int r;
    m = mag_of(y);
    if (m >= HALF) r = ONE;
    else if (m == 0) r = 0;
    else r = tab[int'(m)];
    return y[31] ? 32'(-r) : 32'(r);
  endfunction

  function automatic int model_lat(input logic [31:0] y);
    return (mag_of(y) >= HALF) ? 1 : BPL + 1;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) i_ready = 1'b1;
      else if (rdy_mode == 1) i_ready = 1'b0;
      else i_ready = 1'($urandom_range(0, 1));
    end
  end

  // output-side scoreboard: value, latency, hold stability, busy ready, monotonicity
  initial begin
    bit          prev_valid;
    int          rise_cyc;
    logic [31:0] held;
    exp_t        e;
    prev_valid = 1'b0;
    rise_cyc = 0;
    held = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (o_valid) begin
          if (!prev_valid) begin
            rise_cyc = cyc;
            held = o_sample;
          end else begin
            check_eq("hold_sample", o_sample, held);
          end
          check_eq("busy_ready", 32'(o_ready), 32'd0);
          if (i_ready) begin
            last_hs = cyc;
            if (q.size() == 0) begin
              check_eq("unexpected_out", 32'(q.size()), 32'd1);
            end else begin
              e = q.pop_front();
              check_eq("value", o_sample, e.exp);
              check_eq("latency", 32'(rise_cyc - e.acc), 32'(e.lat));
              if (mono_on) begin
                if (mono_have) check_eq("monotonic", 32'($signed(o_sample) >= $signed(mono_prev)), 32'd1);
                mono_prev = o_sample;
                mono_have = 1'b1;
              end
            end
          end
        end
        prev_valid = o_valid;
      end
    end
  end

  // present a sample and hold it until accepted; called at posedge+1 phase
  task automatic send(input logic [31:0] y, input logic [31:0] exp, input int lat);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    i_sample = y;
    i_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      if (o_ready) acc = 1'b1;
      else n++;
    end
    if (!acc) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
    end else begin
      q.push_back('{exp: exp, lat: lat, acc: cyc});
      if (chk_period && prev_acc >= 0) check_eq("period", 32'(cyc - prev_acc), 32'd14);
      prev_acc = cyc;
      last_acc = cyc;
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dir_y[6];
    logic [31:0] dir_e[6];
    int          dir_l[6];
    longint      fv;
    logic [31:0] y;

    for (int m = 0; m < HALF; m++) tab[m] = -1;
    for (int x = 0; x <= ONE; x++) begin
      fv = fwd(longint'(x));
      if (fv < HALF) tab[int'(fv)] = x;
    end
    for (int m = 1; m < HALF; m++) if (tab[m] < 0) tab[m] = tab[m-1];

    dir_y = '{32'd0, 32'd2048, -32'sd3000, 32'h8000_0000, 32'd1024, -32'sd1024};
    dir_e = '{32'd0, 32'd4096, -32'sd4096, -32'sd4096,    32'd1423, -32'sd1423};
    dir_l = '{13, 1, 1, 1, 13, 13};

    rst_n = 1'b0;
    i_valid = 1'b0;
    i_sample = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(o_ready), 32'd1);
    check_eq("rst_valid", 32'(o_valid), 32'd0);
    check_eq("rst_sample", o_sample, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) send(dir_y[i], dir_e[i], dir_l[i]);
    drain();

    // downstream stall: output held, new sample refused until the handshake
    rdy_mode = 1;
    send(32'd500, model_val(32'd500), model_lat(32'd500));
    for (int n = 0; n < 50 && !o_valid; n++) begin
      @(posedge clk);
      #1;
    end
    i_sample = 32'd700;
    i_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_eq("stall_valid", 32'(o_valid), 32'd1);
    check_eq("stall_ready", 32'(o_ready), 32'd0);
    rdy_mode = 0;
    send(32'd700, model_val(32'd700), model_lat(32'd700));
    check_eq("accept_after_hs", 32'(last_acc - last_hs), 32'd1);
    drain();

    // asynchronous abort in the middle of the search
    send(32'd1024, 32'd1423, 13);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("abort_valid", 32'(o_valid), 32'd0);
    check_eq("abort_ready", 32'(o_ready), 32'd1);
    check_eq("abort_sample", o_sample, 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (20) @(posedge clk);
    #1;
    check_eq("no_stale_valid", 32'(o_valid), 32'd0);
    check_eq("idle_ready", 32'(o_ready), 32'd1);

    // back-to-back sweep over the non-saturating range
    chk_period = 1'b1;
    prev_acc = -1;
    mono_on = 1'b1;
    mono_have = 1'b0;
    for (int v = -2047; v <= 2047; v++) begin
      y = 32'(v);
      send(y, model_val(y), model_lat(y));
    end
    drain();
    chk_period = 1'b0;
    mono_on = 1'b0;

    // random samples, gaps and downstream back-pressure
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      if ($urandom_range(0, 7) == 0) y = $urandom;
      else y = 32'(int'($urandom_range(0, 8191)) - 4096);
      send(y, model_val(y), model_lat(y));
    end
    rdy_mode = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
